rv_fetch_unit: RTL and testbench



---
 rtl/rv_fetch_pkg.sv | 22 ++
 rtl/rv_fetch_fifo.sv | 64 ++++++
 rtl/rv_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_rv_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and constants for the RV32I instruction fetch front end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_INSTR        : canonical ADDI x0,x0,0 used as filler for faulting entries
//   fetch_entry_t    : one prefetch buffer entry {pc, instr, fault}
//   cnt_width()      : bits needed to hold a counter ranging 0..max_count
// Optional feature macro used by the fetch unit: FETCH_MISALIGN_TRAP_EN.
package rv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : empties the FIFO; wins over a push in the same cycle
//   push/push_data, pop : write and read strobes (pop of an empty FIFO is ignored)
//   head         : entry at the read pointer, valid when !empty
//   count/full/empty : occupancy status from registered state
// Push and pop may coincide when full (slot reused) or empty is never popped.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  fetch_entry_t                push_data,
  input  logic                        pop,
  output fetch_entry_t                head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify strobes: pop needs data, push needs a slot (possibly freed by this pop).
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointer and occupancy registers; flush restarts the FIFO empty.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I instruction fetch front end with a prefetch FIFO.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   redirect_valid/pc       : control-flow change from execute; flushes and refetches
//   imem_req_valid/ready/addr : word fetch requests, address held until accepted
//   imem_rsp_valid/data     : in-order responses, no backpressure
//   out_valid/ready/pc/instr/fault : head of prefetch FIFO towards decode
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// delivers one faulting NOP entry and stalls fetch; without it low bits are masked.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int IW = cnt_width(MAX_OUTSTANDING);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [31:0]  fetch_pc_r, fetch_pc_n_s;
  logic [31:0]  rsp_pc_r, rsp_pc_n_s;
  logic [IW-1:0] inflight_r, inflight_n_s;
  logic [IW-1:0] drop_r, drop_n_s;
  logic         boot_r;
  logic         req_fire_s;
  logic         rsp_ok_s;
  logic         fetch_en_s;
  logic [31:0]  credit_use_s;
  logic         fifo_flush_s, fifo_push_s, fifo_pop_s;
  fetch_entry_t fifo_push_data_s, fifo_head_s;
  logic [CW-1:0] fifo_count_s;
  logic         fifo_full_s, fifo_empty_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         stall_r, stall_n_s;
  logic         fault_pend_r, fault_pend_n_s;
  logic [31:0]  fault_pc_r, fault_pc_n_s;
  assign fetch_en_s = !stall_r;
`else
  assign fetch_en_s = 1'b1;
`endif

  // Slots already promised: buffered entries plus responses that will be kept.
  assign credit_use_s = 32'(fifo_count_s) + 32'(inflight_r) - 32'(drop_r);

  // boot_r blanks the first cycle after reset; the credit check guarantees a kept
  // response always finds a free FIFO slot, so the request cannot drop out early.
  assign imem_req_valid = !reset && !boot_r && !redirect_valid && fetch_en_s &&
                          !fifo_full_s &&
                          (32'(inflight_r) < 32'(MAX_OUTSTANDING)) &&
                          (credit_use_s < 32'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_ok_s       = imem_rsp_valid && (inflight_r != {IW{1'b0}});

  // Next-state: redirect overrides everything, otherwise track requests/responses.
  always_comb begin
    fetch_pc_n_s     = fetch_pc_r;
    rsp_pc_n_s       = rsp_pc_r;
    inflight_n_s     = inflight_r;
    drop_n_s         = drop_r;
    fifo_flush_s     = 1'b0;
    fifo_push_s      = 1'b0;
    fifo_pop_s       = 1'b0;
    fifo_push_data_s = '{pc: rsp_pc_r, instr: imem_rsp_data, fault: 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    stall_n_s        = stall_r;
    fault_pend_n_s   = fault_pend_r;
    fault_pc_n_s     = fault_pc_r;
`endif
    if (redirect_valid) begin
      // Every response still owed, including none arriving now, is stale.
      fifo_flush_s = 1'b1;
      inflight_n_s = inflight_r - IW'(rsp_ok_s);
      drop_n_s     = inflight_r - IW'(rsp_ok_s);
      fetch_pc_n_s = redirect_pc & 32'hFFFF_FFFC;
      rsp_pc_n_s   = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      stall_n_s      = (redirect_pc[1:0] != 2'b00);
      fault_pend_n_s = (redirect_pc[1:0] != 2'b00);
      fault_pc_n_s   = redirect_pc;
`endif
    end else begin
      fifo_pop_s   = !fifo_empty_s && out_ready;
      inflight_n_s = inflight_r + IW'(req_fire_s) - IW'(rsp_ok_s);
      if (req_fire_s) begin
        fetch_pc_n_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_n_s = fetch_pc_r;
      end
      if (rsp_ok_s && (drop_r != {IW{1'b0}})) begin
        drop_n_s = drop_r - IW'(1);
      end else if (rsp_ok_s) begin
        fifo_push_s = 1'b1;
        rsp_pc_n_s  = rsp_pc_r + 32'd4;
      end else begin
        drop_n_s = drop_r;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // Deferred one cycle so the flush of the redirect cycle cannot swallow it;
      // all responses are being dropped then, so this push never collides.
      if (fault_pend_r) begin
        fifo_push_s      = 1'b1;
        fifo_push_data_s = '{pc: fault_pc_r, instr: NOP_INSTR, fault: 1'b1};
        fault_pend_n_s   = 1'b0;
      end else begin
        fault_pend_n_s = 1'b0;
      end
`endif
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      inflight_r <= {IW{1'b0}};
      drop_r     <= {IW{1'b0}};
      boot_r     <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      stall_r      <= 1'b0;
      fault_pend_r <= 1'b0;
      fault_pc_r   <= 32'h0000_0000;
`endif
    end else begin
      fetch_pc_r <= fetch_pc_n_s;
      rsp_pc_r   <= rsp_pc_n_s;
      inflight_r <= inflight_n_s;
      drop_r     <= drop_n_s;
      boot_r     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      stall_r      <= stall_n_s;
      fault_pend_r <= fault_pend_n_s;
      fault_pc_r   <= fault_pc_n_s;
`endif
    end
  end

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush_s),
    .push      (fifo_push_s),
    .push_data (fifo_push_data_s),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Fault is only ever stored as 1 when the misalign trap is built in.
  assign out_valid = !fifo_empty_s;
  assign out_pc    = fifo_head_s.pc;
  assign out_instr = fifo_head_s.instr;
  assign out_fault = !fifo_empty_s && fifo_head_s.fault;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed + random bench for rv_fetch_unit with an in-order
// variable-latency memory model and an expected-output scoreboard queue.
module tb_rv_fetch_unit;
  import rv_fetch_pkg::*;

  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  rv_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          last_due = 0;
  int          mem_lat = 1;
  int          hs_count = 0;
  int          obs_cyc = 0;
  bit          rand_mode = 1'b0;
  bit          req_seen = 1'b0;
  logic        obs_out_valid, obs_req_valid, obs_out_fault, obs_rsp_valid;
  logic [31:0] last_out_pc = 32'h0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back('{pc: start + 32'(4 * i), instr: mem_fn(start + 32'(4 * i)), fault: 1'b0});
    end
  endtask

  // One clock cycle: drive memory response, observe just after negedge, model the posedge.
  task automatic step();
    pend_t        p;
    fetch_entry_t e;
    int           d;
    if (rand_mode) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 3) != 0);
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_fn(p.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    check("inflight_le_max", 32'(n_out <= MAX_OUT), 32'd1);
    obs_cyc       = cyc;
    obs_out_valid = out_valid;
    obs_req_valid = imem_req_valid;
    obs_out_fault = out_fault;
    obs_rsp_valid = imem_rsp_valid;
    if (imem_req_valid) req_seen = 1'b1;
    if (imem_rsp_valid) n_out--;
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + (rand_mode ? int'($urandom_range(1, 4)) : mem_lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_q.push_back('{addr: imem_req_addr, due: d});
      n_out++;
    end
    if (out_valid && out_ready && !redirect_valid && !reset) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_out", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_fault", 32'(out_fault), 32'(e.fault));
      end
      hs_count++;
      last_out_pc = out_pc;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
    pend_q.delete(); n_out = 0; last_due = 0; hs_count = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_req_valid", 32'(obs_req_valid), 32'd0);
      check("rst_out_valid", 32'(obs_out_valid), 32'd0);
      check("rst_out_fault", 32'(obs_out_fault), 32'd0);
    end
    exp_fill(RST_PC);
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    exp_fill(target & 32'hFFFF_FFFC);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int hs0);
    for (int i = 0; i < 30; i++) begin
      if (hs_count > hs0) break;
      step();
    end
    check(tag, 32'(hs_count > hs0), 32'd1);
  endtask

  initial begin
    int rel, first, hs0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; out_ready = 1'b0;
    @(negedge clock);
    do_reset();

    // Reset release with a 1-cycle memory and a ready consumer.
    imem_req_ready = 1'b1; out_ready = 1'b1; mem_lat = 1; rel = cyc;
    step();
    check("post_rst_req_valid", 32'(obs_req_valid), 32'd0);
    check("post_rst_out_valid", 32'(obs_out_valid), 32'd0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_out_valid) begin first = obs_cyc; break; end
    end
    check("first_valid_latency", 32'(first - rel), 32'd3);
    step(); check("t1_valid_2", 32'(obs_out_valid), 32'd1);
    step(); check("t1_valid_3", 32'(obs_out_valid), 32'd1);
    check("t1_hs", 32'(hs_count), 32'd3);
    check("t1_last_pc", last_out_pc, 32'h8000_0008);

    // Consumer stall: buffer fills to exactly FIFO_DEPTH, fetch halts.
    out_ready = 1'b0;
    repeat (20) step();
    check("t2_req_blocked", 32'(obs_req_valid), 32'd0);
    check("t2_none_inflight", 32'(n_out), 32'd0);
    check("t2_out_valid", 32'(obs_out_valid), 32'd1);
    imem_req_ready = 1'b0; out_ready = 1'b1; hs0 = hs_count;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!obs_out_valid) break;
    end
    check("t2_held_entries", 32'(hs_count - hs0), 32'd4);
    imem_req_ready = 1'b1; hs0 = hs_count;
    repeat (8) step();
    check("t2_resumed", 32'(hs_count > hs0), 32'd1);

    // Redirect with two requests in flight, latency 3.
    mem_lat = 3;
    repeat (6) step();
    for (int i = 0; i < 20; i++) begin
      if (n_out == MAX_OUT) break;
      step();
    end
    check("t3_two_inflight", 32'(n_out), 32'd2);
    hs0 = hs_count;
    do_redirect(32'h8000_0100);
    wait_out("t3_out_after_redirect", hs0);
    check("t3_first_pc", last_out_pc, 32'h8000_0100);

    // Redirect colliding with a response and an output handshake.
    mem_lat = 1;
    repeat (8) step();
    hs0 = hs_count;
    do_redirect(32'h8000_0200);
    check("t4_rsp_in_redirect", 32'(obs_rsp_valid), 32'd1);
    check("t4_out_in_redirect", 32'(obs_out_valid), 32'd1);
    check("t4_hs_ignored", 32'(hs_count), 32'(hs0));
    wait_out("t4_out_after_redirect", hs0);
    check("t4_first_pc", last_out_pc, 32'h8000_0200);

    // Random ready and latency 1..4 with a random consumer.
    hs0 = hs_count;
    rand_mode = 1'b1;
    repeat (300) step();
    rand_mode = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (20) step();
    check("t5_progress", 32'(hs_count - hs0 > 40), 32'd1);

    // Misaligned redirect target.
    hs0 = hs_count; req_seen = 1'b0;
    do_redirect(32'h8000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_q.delete();
    exp_q.push_back('{pc: 32'h8000_0102, instr: NOP_INSTR, fault: 1'b1});
    repeat (20) step();
    check("t6_one_entry", 32'(hs_count - hs0), 32'd1);
    check("t6_fault_pc", last_out_pc, 32'h8000_0102);
    check("t6_no_fetch", 32'(req_seen), 32'd0);
`else
    wait_out("t6_out_after_redirect", hs0);
    check("t6_masked_pc", last_out_pc, 32'h8000_0100);
    check("t6_fetching", 32'(req_seen), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
